sd_cmd_arbiter: RTL and testbench

SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

---
 rtl/sd_cmd_arbiter.sv | 124 ++++++++++++
 tb/tb_sd_cmd_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: round-robin two-requester SD command arbiter with send/response sequencing, timeouts and retry.
module sd_cmd_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd5000,
  parameter int          MAX_RETRY      = 2
) (
  input  logic         ex_clk,
  input  logic         ex_resetn,
  input  logic [1:0]   req,
  input  logic [37:0]  req_cmd0,
  input  logic [37:0]  req_cmd1,
  input  logic [1:0]   req_rtype0,
  input  logic [1:0]   req_rtype1,
  output logic         send_en,
  output logic [37:0]  send_cmd_content,
  input  logic         sd_cmd_sending,
  output logic         receive_en,
  output logic         R2_response,
  input  logic         sd_receive_finished,
  input  logic         crc_response_err,
  input  logic [126:0] response,
  output logic [1:0]   grant,
  output logic [1:0]   done,
  output logic [1:0]   err_code,
  output logic [126:0] resp_data
);
  typedef enum logic [2:0] {IDLE, SEND, SENDING, WAIT_RESP, DONE} state_t;
  state_t         state_q;
  logic [1:0]     grant_q, done_q, err_q, rtype_q;
  logic [37:0]    cmd_q;
  logic [126:0]   resp_q;
  logic [15:0]    cnt_q;
  logic [7:0]     retry_q;
  logic           send_en_q, receive_en_q, r2_q, seen_q, last_q;
  logic           win, tmo, can_retry;
  assign win       = &req ? ~last_q : req[1];
  assign tmo       = cnt_q >= TIMEOUT_CYCLES - 16'd1;
  assign can_retry = retry_q < 8'(MAX_RETRY);
  assign send_en          = send_en_q;
  assign send_cmd_content = cmd_q;
  assign receive_en       = receive_en_q;
  assign R2_response      = r2_q;
  assign grant            = grant_q;
  assign done             = done_q;
  assign err_code         = err_q;
  assign resp_data        = resp_q;
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      rtype_q      <= '0;
      cmd_q        <= '0;
      resp_q       <= '0;
      cnt_q        <= '0;
      retry_q      <= '0;
      send_en_q    <= 1'b0;
      receive_en_q <= 1'b0;
      r2_q         <= 1'b0;
      seen_q       <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      // the timeout counter only runs in the two wait states and restarts on every entry
      cnt_q <= (state_q == SENDING || state_q == WAIT_RESP) ? ((&cnt_q) ? cnt_q : cnt_q + 16'd1) : '0;
      case (state_q)
        IDLE: if (|req) begin
          grant_q   <= win ? 2'b10 : 2'b01;
          last_q    <= win;
          cmd_q     <= win ? req_cmd1 : req_cmd0;
          rtype_q   <= win ? req_rtype1 : req_rtype0;
          retry_q   <= '0;
          send_en_q <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          send_en_q <= 1'b0;
          seen_q    <= 1'b0;
          state_q   <= SENDING;
        end
        SENDING: if (sd_cmd_sending) seen_q <= 1'b1;
        else if (seen_q) begin
          if (rtype_q == 2'b00) begin
            done_q  <= grant_q;
            err_q   <= 2'b00;
            state_q <= DONE;
          end else begin
            receive_en_q <= 1'b1;
            r2_q         <= rtype_q == 2'b10;
            cnt_q        <= '0;
            state_q      <= WAIT_RESP;
          end
        end else if (tmo) begin
          done_q  <= grant_q;
          err_q   <= 2'b11;
          state_q <= DONE;
        end
        WAIT_RESP: if (sd_receive_finished || tmo) begin
          if (sd_receive_finished) resp_q <= response;
          receive_en_q <= 1'b0;
          r2_q         <= 1'b0;
          if (sd_receive_finished && !crc_response_err) begin
            done_q  <= grant_q;
            err_q   <= 2'b00;
            state_q <= DONE;
          end else if (can_retry) begin
            retry_q   <= retry_q + 8'd1;
            send_en_q <= 1'b1;
            state_q   <= SEND;
          end else begin
            done_q  <= grant_q;
            err_q   <= sd_receive_finished ? 2'b01 : 2'b10;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= '0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// tb_sd_cmd_arbiter: scoreboard bench with directed sender/receiver behaviour models.
module tb_sd_cmd_arbiter;
  localparam logic [15:0] TO = 16'd30;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [1:0]   req = '0, req_rtype0 = '0, req_rtype1 = '0;
  logic [37:0]  req_cmd0 = '0, req_cmd1 = '0;
  logic         busy = 1'b0, fin = 1'b0, crc = 1'b0;
  logic [126:0] response = '0;
  logic         send_en, receive_en, R2_response;
  logic [37:0]  send_cmd_content;
  logic [1:0]   grant, done, err_code;
  logic [126:0] resp_data;
  typedef struct { logic [1:0] d; logic [1:0] e; logic [126:0] r; logic cr; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, sends = 0, busy_len = 3, rx_delay = -1;
  logic         rx_crc = 1'b0, exp_r2 = 1'b0, recv_seen = 1'b0;
  logic [126:0] rx_resp = '0;
  logic [37:0]  exp_cmd = '0;
  time          fall_t = 0, t0 = 0;
  sd_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(2)) dut (
    .ex_clk(clk), .ex_resetn(rst_n), .req(req), .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .req_rtype0(req_rtype0), .req_rtype1(req_rtype1), .send_en(send_en),
    .send_cmd_content(send_cmd_content), .sd_cmd_sending(busy), .receive_en(receive_en),
    .R2_response(R2_response), .sd_receive_finished(fin), .crc_response_err(crc),
    .response(response), .grant(grant), .done(done), .err_code(err_code), .resp_data(resp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [126:0] act, input logic [126:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_done(input logic [1:0] b, input int budget);
    int n = 0;
    while (done !== b && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== b) begin
      errors++;
      $display("FAIL wait_done: got done=%b expected %b within %0d cycles", done, b, budget);
    end
  endtask
  // scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t x;
    if (done !== 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got %b expected none", done);
      end else begin
        x = sb.pop_front();
        chk("done", done, x.d);
        chk("err_code", err_code, x.e);
        if (x.cr) chk("resp_data", resp_data, x.r);
      end
    end
    if (receive_en) recv_seen = 1'b1;
  end
  initial forever begin
    @(negedge clk);
    if (send_en) begin
      sends++;
      chk("send_cmd", send_cmd_content, exp_cmd);
      if (busy_len > 0) begin
        @(negedge clk) busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy = 1'b0;
        fall_t = $time;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (receive_en && rx_delay >= 0) begin
      chk("R2_response", R2_response, exp_r2);
      repeat (rx_delay) @(negedge clk);
      response = rx_resp;
      crc = rx_crc;
      fin = 1'b1;
      @(negedge clk);
      fin = 1'b0;
      crc = 1'b0;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_send_en", send_en, 0);
    chk("rst_receive_en", receive_en, 0);
    chk("rst_err", err_code, 0);
    chk("rst_resp", resp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // round-robin: both held, grants 01,10,01
    req_cmd0 = 38'h01_1111_1111;
    req_cmd1 = 38'h02_2222_2222;
    busy_len = 3;
    sb.push_back('{2'b01, 2'b00, '0, 1'b0});
    sb.push_back('{2'b10, 2'b00, '0, 1'b0});
    sb.push_back('{2'b01, 2'b00, '0, 1'b0});
    exp_cmd = req_cmd0;
    req = 2'b11;
    wait_done(2'b01, 100);
    exp_cmd = req_cmd1;
    wait_done(2'b10, 100);
    exp_cmd = req_cmd0;
    wait_done(2'b01, 100);
    req = 2'b00;
    repeat (3) @(negedge clk);
    // no-response command with long busy
    busy_len = 40;
    sends = 0;
    recv_seen = 1'b0;
    req_cmd0 = 38'h00_0000_0AB0;
    exp_cmd = req_cmd0;
    sb.push_back('{2'b01, 2'b00, '0, 1'b0});
    req = 2'b01;
    wait_done(2'b01, 200);
    req = 2'b00;
    lat = int'(($time - fall_t) / 10);
    checks++;
    if (lat < 1 || lat > 3) begin
      errors++;
      $display("FAIL v1_latency: got %0d cycles expected 1..3", lat);
    end
    chk("v1_sends", sends, 1);
    chk("v1_receive_en", recv_seen, 0);
    repeat (3) @(negedge clk);
    // R2 response on requester 1, req dropped mid-transaction
    busy_len = 5;
    rx_delay = 3;
    rx_resp = 127'h5A;
    rx_crc = 1'b0;
    exp_r2 = 1'b1;
    req_rtype1 = 2'b10;
    req_cmd1 = 38'h02_0000_0002;
    exp_cmd = req_cmd1;
    sb.push_back('{2'b10, 2'b00, 127'h5A, 1'b1});
    req = 2'b10;
    repeat (3) @(negedge clk);
    req = 2'b00;
    wait_done(2'b10, 200);
    repeat (2) @(negedge clk);
    chk("v3_resp_hold", resp_data, 127'h5A);
    // CRC error on every attempt, cmd changed while granted
    sends = 0;
    rx_delay = 2;
    rx_crc = 1'b1;
    rx_resp = 127'h1234;
    exp_r2 = 1'b0;
    req_rtype0 = 2'b01;
    req_cmd0 = 38'h11_0000_0011;
    exp_cmd = req_cmd0;
    sb.push_back('{2'b01, 2'b01, 127'h1234, 1'b1});
    req = 2'b01;
    repeat (4) @(negedge clk);
    req_cmd0 = 38'h22_0000_0022;
    wait_done(2'b01, 300);
    req = 2'b00;
    chk("v4_sends", sends, 3);
    repeat (3) @(negedge clk);
    // response timeout on every attempt
    sends = 0;
    rx_delay = -1;
    rx_crc = 1'b0;
    exp_cmd = req_cmd0;
    sb.push_back('{2'b01, 2'b10, '0, 1'b0});
    req = 2'b01;
    wait_done(2'b01, 400);
    req = 2'b00;
    chk("resp_timeout_sends", sends, 3);
    repeat (3) @(negedge clk);
    // sender never goes busy
    sends = 0;
    busy_len = 0;
    sb.push_back('{2'b01, 2'b11, '0, 1'b0});
    t0 = $time;
    req = 2'b01;
    wait_done(2'b01, 200);
    req = 2'b00;
    lat = int'(($time - t0) / 10);
    checks++;
    if (lat < int'(TO) || lat > int'(TO) + 4) begin
      errors++;
      $display("FAIL v5_latency: got %0d cycles expected %0d..%0d", lat, TO, TO + 4);
    end
    chk("v5_sends", sends, 1);
    repeat (3) @(negedge clk);
    // asynchronous reset during WAIT_RESP
    busy_len = 3;
    req = 2'b10;
    req_rtype1 = 2'b01;
    exp_cmd = req_cmd1;
    begin
      int n = 0;
      while (!receive_en && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("v6_in_wait", receive_en, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("v6_grant", grant, 0);
    chk("v6_receive_en", receive_en, 0);
    chk("v6_err", err_code, 0);
    chk("v6_resp", resp_data, 0);
    chk("v6_done", done, 0);
    @(negedge clk);
    req = 2'b00;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    req_rtype0 = 2'b00;
    req_rtype1 = 2'b00;
    exp_cmd = req_cmd0;
    sb.push_back('{2'b01, 2'b00, '0, 1'b0});
    req = 2'b11;
    wait_done(2'b01, 100);
    req = 2'b00;
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
